// File: rtl/he_pkg.sv
// he_pkg: shared widths, row-index sizing helper and FSM encoding for the HE datapath blocks.
package he_pkg;
  localparam int CT_WIDTH_DEF = 6;
  function automatic int row_width(input int entries);
    return entries > 1 ? $clog2(entries) : 1;
  endfunction
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
endpackage

// File: rtl/key_power_gen.sv
// key_power_gen: holds the secret key and steps the power chain 1, s, s^2, ... mod 2^W.
module key_power_gen
  import he_pkg::*;
#(
  parameter int W = CT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_key,
  input  logic [W-1:0] key,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] power
);
  logic [W-1:0] key_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg <= '0;
      power   <= W'(1);
    end else begin
      if (load_key) key_reg <= key;
      power <= clear ? W'(1) : step ? W'(power * key_reg) : power;
    end
  end
endmodule

// File: rtl/decrypt_feeder.sv
// decrypt_feeder: buffers one ciphertext and streams (row, s^row, entry) beats to decrypt.
module decrypt_feeder
  import he_pkg::*;
#(
  parameter int CIPHERTEXT_WIDTH = CT_WIDTH_DEF,
  parameter int MAX_ENTRIES      = 3,
  parameter int ROW_WIDTH        = row_width(MAX_ENTRIES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CIPHERTEXT_WIDTH-1:0] secret_key,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] in_entry,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROW_WIDTH-1:0]        out_row,
  output logic [CIPHERTEXT_WIDTH-1:0] out_skentry,
  output logic [CIPHERTEXT_WIDTH-1:0] out_ctentry,
  output logic                        done
);
  localparam int CW = $clog2(MAX_ENTRIES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ENTRIES);
  state_t state;
  logic [CW-1:0] count;
  logic [ROW_WIDTH-1:0] row;
  logic [CIPHERTEXT_WIDTH-1:0] mem [2**ROW_WIDTH];
  logic load_beat, out_beat, last_row;
  assign in_ready    = state == IDLE || state == LOAD;
  assign out_valid   = state == STREAM;
  assign done        = state == DONE;
  assign load_beat   = in_valid && in_ready;
  assign out_beat    = out_valid && out_ready;
  assign last_row    = row == ROW_WIDTH'(count - 1'b1);
  assign out_row     = row;
  assign out_ctentry = out_valid ? mem[row] : '0;
  // count is zero in IDLE, so it doubles as the write address for every load beat
  always_ff @(posedge clk) begin
    if (load_beat) mem[ROW_WIDTH'(count)] <= in_entry;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      row   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          count <= CW'(1);
          state <= in_last || MAX_ENTRIES == 1 ? STREAM : LOAD;
        end
        LOAD: if (in_valid) begin
          count <= count + 1'b1;
          state <= in_last || count + 1'b1 == MAX_CNT ? STREAM : LOAD;
        end
        STREAM: if (out_ready) begin
          row   <= row + 1'b1;
          state <= last_row ? DONE : STREAM;
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
          row   <= '0;
        end
      endcase
    end
  end
  key_power_gen #(.W(CIPHERTEXT_WIDTH)) u_kpg (
    .clk     (clk),
    .rst     (rst),
    .load_key(state == IDLE && in_valid),
    .key     (secret_key),
    .step    (out_beat),
    .clear   (done),
    .power   (out_skentry)
  );
endmodule

// File: tb/tb_decrypt_feeder.sv
// tb_decrypt_feeder: directed and random ciphertexts checked against a queue-based model.
module tb_decrypt_feeder;
  localparam int MAXE = 3;
  logic clk = 0, rst;
  logic [5:0] secret_key, in_entry, out_skentry, out_ctentry;
  logic in_valid, in_ready, in_last, out_valid, out_ready, done;
  logic [1:0] out_row;
  int tests = 0, fails = 0, cyc = 0;
  int mdl_ent[$], exp_row[$], exp_sk[$], exp_ct[$], lg_row[$], lg_sk[$], lg_ct[$];
  bit sealed = 0, or_rand = 0;
  int key, first_cyc, done_cyc;
  logic [5:0] ld [4];

  decrypt_feeder dut (
    .clk(clk), .rst(rst), .secret_key(secret_key), .in_valid(in_valid), .in_ready(in_ready),
    .in_entry(in_entry), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_skentry(out_skentry), .out_ctentry(out_ctentry), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst done", done, 0);
      chk("rst out_row", out_row, 0);
      chk("rst skentry", out_skentry, 1);
      chk("rst ctentry", out_ctentry, 0);
      sealed = 0;
      mdl_ent.delete(); exp_row.delete(); exp_sk.delete(); exp_ct.delete();
    end else begin
      automatic bit ev = sealed && exp_row.size() > 0;
      automatic bit ed = sealed && exp_row.size() == 0;
      chk("in_ready", in_ready, !sealed);
      chk("out_valid", out_valid, ev);
      chk("done", done, ed);
      if (ev) begin
        chk("out_row", out_row, exp_row[0]);
        chk("out_skentry", out_skentry, exp_sk[0]);
        chk("out_ctentry", out_ctentry, exp_ct[0]);
        if (out_ready) begin
          lg_row.push_back(out_row); lg_sk.push_back(out_skentry); lg_ct.push_back(out_ctentry);
          void'(exp_row.pop_front()); void'(exp_sk.pop_front()); void'(exp_ct.pop_front());
        end
      end
      if (ed) begin
        done_cyc = cyc;
        sealed = 0;
        mdl_ent.delete();
      end else if (!sealed && in_valid) begin
        if (mdl_ent.size() == 0) begin
          key = secret_key;
          first_cyc = cyc;
        end
        mdl_ent.push_back(in_entry);
        if (in_last || mdl_ent.size() == MAXE) begin
          automatic int p = 1;
          sealed = 1;
          foreach (mdl_ent[i]) begin
            exp_row.push_back(i); exp_sk.push_back(p); exp_ct.push_back(mdl_ent[i]);
            p = (p * key) % 64;
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (or_rand) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic load(input int k, input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin in_valid = 0; @(posedge clk); #1; end
      in_valid = 1; in_entry = ld[i]; in_last = use_last && i == n - 1;
      secret_key = (i == 0 || !gaps) ? 6'(k) : 6'($urandom);
      for (int t = 0; ; t++) begin
        automatic logic acc;
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
        if (acc) break;
        if (t > 60) begin
          tests++; fails++;
          $display("FAIL load timeout: in_ready stuck at %0d, required 1", in_ready);
          break;
        end
      end
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_idle();
    for (int t = 0; ; t++) begin
      @(posedge clk); #1;
      if (!sealed && mdl_ent.size() == 0) break;
      if (t > 200) begin
        tests++; fails++;
        $display("FAIL idle timeout: done never seen, %0d beats pending, required 0", exp_row.size());
        break;
      end
    end
  endtask

  task automatic clear_log();
    lg_row.delete(); lg_sk.delete(); lg_ct.delete();
  endtask

  task automatic chk_log(input string nm, input int i, input int r, input int s, input int c);
    if (i < lg_row.size()) begin
      chk({nm, " row"}, lg_row[i], r);
      chk({nm, " sk"}, lg_sk[i], s);
      chk({nm, " ct"}, lg_ct[i], c);
    end else chk({nm, " beat count"}, lg_row.size(), i + 1);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_entry = 0; in_last = 0; secret_key = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    clear_log();
    ld[0] = 38; ld[1] = 62; ld[2] = 52;
    load(20, 3, 1, 0);
    wait_idle();
    chk_log("product b0", 0, 0, 1, 38);
    chk_log("product b1", 1, 1, 20, 62);
    chk_log("product b2", 2, 2, 16, 52);
    chk("product latency", done_cyc - first_cyc, 6);
    clear_log();
    ld[0] = 26;
    load(33, 1, 1, 0);
    wait_idle();
    chk_log("single b0", 0, 0, 1, 26);
    chk("single latency", done_cyc - first_cyc, 2);
    chk("single beats", lg_row.size(), 1);
    clear_log();
    ld[0] = 5; ld[1] = 49; ld[2] = 7;
    load(20, 3, 0, 0);
    in_valid = 1; in_entry = 9;
    @(negedge clk);
    chk("forced refuse 9", in_ready, 0);
    @(posedge clk); #1 in_valid = 0;
    wait_idle();
    chk("forced beats", lg_row.size(), 3);
    chk_log("forced b2", 2, 2, 16, 7);
    clear_log();
    ld[0] = 1; ld[1] = 2; ld[2] = 3;
    load(63, 3, 1, 0);
    foreach (ld[i]) if (i < 4) begin
      @(posedge clk); #1 out_ready = i == 0 || i == 1 ? 1'b0 : 1'b1;
    end
    wait_idle();
    chk_log("wrap b0", 0, 0, 1, 1);
    chk_log("wrap b1", 1, 1, 63, 2);
    chk_log("wrap b2", 2, 2, 1, 3);
    chk("wrap latency", done_cyc - first_cyc, 8);
    clear_log();
    ld[0] = 38; ld[1] = 62; ld[2] = 52;
    load(20, 3, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst in_ready", in_ready, 1);
    chk("beats before rst", lg_row.size(), 2);
    @(posedge clk); #1 rst = 0;
    repeat (4) @(posedge clk);
    #1 clear_log();
    ld[0] = 11; ld[1] = 12;
    load(20, 2, 1, 0);
    wait_idle();
    chk_log("restart b0", 0, 0, 1, 11);
    chk_log("restart b1", 1, 1, 20, 12);
    or_rand = 1;
    for (int it = 0; it < 40; it++) begin
      automatic int n = $urandom_range(1, MAXE);
      for (int i = 0; i < 4; i++) ld[i] = 6'($urandom);
      load($urandom_range(0, 63), n, n < MAXE ? 1'b1 : 1'($urandom_range(0, 1)), 1);
      wait_idle();
    end
    or_rand = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decrypt_feeder.md
Name: decrypt_feeder

Overview:
- Transmit side of the row-serial (row, secret-key entry, ciphertext entry) interface consumed by `decrypt`.
- Buffers a ciphertext of 1..MAX_ENTRIES entries, such as the (DIMENSION+2)-entry output of `homomorphic_multiply`.
- Generates the matching secret-key power vector [1, s, s^2, ...] mod 2^CIPHERTEXT_WIDTH on the fly.
- Streams one row per accepted beat, then pulses `done` when the downstream decrypt result is valid.

Parameters:
- CIPHERTEXT_WIDTH, 6, entry width; all arithmetic is mod 2^CIPHERTEXT_WIDTH.
- MAX_ENTRIES, 3, buffer depth (ciphertext entries per decryption).
- ROW_WIDTH, 2, width of row index; must satisfy 2^ROW_WIDTH >= MAX_ENTRIES.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- secret_key  in  CIPHERTEXT_WIDTH  scalar secret s; sampled with the first accepted load beat.
- in_valid  in  1  load entry valid.
- in_ready  out  1  block accepts a load entry this cycle.
- in_entry  in  CIPHERTEXT_WIDTH  ciphertext entry; entries arrive in row order 0,1,2...
- in_last  in  1  marks final entry of the ciphertext.
- out_valid  out  1  out_row/out_skentry/out_ctentry valid.
- out_ready  in  1  downstream consumes beat.
- out_row  out  ROW_WIDTH  row index presented to decrypt.
- out_skentry  out  CIPHERTEXT_WIDTH  s^out_row mod 2^CIPHERTEXT_WIDTH.
- out_ctentry  out  CIPHERTEXT_WIDTH  buffered entry for out_row.
- done  out  1  one-cycle pulse; decrypt result is valid this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: in_ready=1; out_valid=0; done=0; out_row=0; out_skentry=1; out_ctentry=0. State IDLE, entry count 0.
- Only state and count are reset; buffer contents are don't-care.
- Handshake: a beat transfers on a rising clk edge with valid&ready high. out_row/out_skentry/out_ctentry are held stable while out_valid=1 and out_ready=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid: store entry 0, latch s into key_reg, count=1.
  - If in_last or MAX_ENTRIES==1, go to STREAM; else go to LOAD.
- FSM LOAD:
  - in_ready=1.
  - On in_valid: store entry[count], count++.
  - If in_last, or count reaches MAX_ENTRIES, go to STREAM. The count limit forces termination; further entries are not accepted.
- FSM STREAM:
  - in_ready=0; in_valid is ignored.
  - out_valid=1. First out_valid is the cycle after the last load beat.
  - On out_ready: advance row; update power = (power * key_reg) truncated to CIPHERTEXT_WIDTH bits, i.e. the low bits of the full-width product.
  - Power sequence is 1, s, s^2, ...
  - After the beat with row == count-1, go to DONE.
- FSM DONE:
  - out_valid=0; done=1 for exactly one cycle.
  - Next state IDLE. Row and power reset to 0 and 1.
  - in_ready=0 in DONE, so a new ciphertext is accepted no earlier than the cycle after done.
- Latency: N entries with out_ready held high give N load cycles, then N stream cycles, then done on the next cycle. Total 2N+1 cycles from first load beat to done.
- in_last is only sampled on accepted beats.
- in_last together with count==MAX_ENTRIES is a single termination, not an error.
- Reset asserted mid-LOAD or mid-STREAM aborts immediately to reset values. No done is issued for the aborted ciphertext.
- key_reg changes only in IDLE. Changing secret_key during LOAD or STREAM has no effect.

Decomposition:
- Shared package `he_pkg`: CIPHERTEXT_WIDTH default, ROW_WIDTH helper (clog2), FSM state typedef {IDLE, LOAD, STREAM, DONE}.
- One sub-module: `key_power_gen`.
  - Holds power register and key_reg.
  - Ports: clk, rst, load_key, key, step, clear, power.
  - Computes mod-2^W power chain, isolating the multiplier.
- Buffer and FSM stay in the top.

Test Plan:
- Product ciphertext:
  - Stimulus: s=20, load 38,62,52 (last on 52), out_ready=1.
  - Required response: out beats (0,1,38), (1,20,62), (2,16,52); done on the following cycle.
  - With `decrypt` attached, result=6.
- Single entry:
  - Stimulus: load 26 with in_last on the first beat.
  - Required response: one beat (0,1,26), then done; in_ready low from STREAM until IDLE.
- Forced termination:
  - Stimulus: MAX_ENTRIES=3, load 5,49,7,9 without in_last.
  - Required response: 9 is refused (in_ready=0); 3 beats streamed.
- Backpressure and wrap-around:
  - Stimulus: s=63, load 1,2,3; out_ready toggled 1,0,0,1,1.
  - Required response: outputs held while stalled; skentry sequence 1,63,1 (63^2 mod 64 = 1).
- Reset mid-stream:
  - Stimulus: assert rst after row 1 beat.
  - Required response: out_valid=0 and in_ready=1 asynchronously; no done.
  - Next load s=20 restarts at row 0 with skentry=1.
